// File: rtl/bram_loader.sv
// Byte-stream boot loader: packs incoming bytes little-endian into 32-bit words
// and writes them to consecutive BRAM addresses, holding the core until the load completes.
module bram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb,
  output logic                  busy,
  output logic                  done,
  output logic                  core_hold
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;

  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      in_ready  <= 1'b0;
      w_enb     <= 1'b0;
      w_addr    <= '0;
      w_dat     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count    <= sat_count(word_count);
            word_idx <= '0;
            byte_idx <= '0;
            if (word_count == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b0;
            end else begin
              state     <= RECV;
              done      <= 1'b0;
              core_hold <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
        end

        RECV: begin
          if (in_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= in_byte;
              2'd1: word_buf[15:8]  <= in_byte;
              2'd2: word_buf[23:16] <= in_byte;
              default: begin
                // Last byte goes straight to the output register; partial bytes
                // stay in word_buf so w_dat only changes when a word is written.
                w_dat    <= {in_byte, word_buf};
                w_addr   <= word_idx;
                w_enb    <= 1'b1;
                in_ready <= 1'b0;
                state    <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          w_enb <= 1'b0;
          if ({1'b0, word_idx} == count - 1'b1) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            word_idx <= word_idx + 1'b1;
            in_ready <= 1'b1;
            state    <= RECV;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Randomized bench for bram_loader: a queue-based model of expected BRAM writes
// and a shadow memory checked against the stream the loader produces.
module tb_bram_loader;

  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_dat;
  logic          w_enb;
  logic          busy;
  logic          done;
  logic          core_hold;

  bram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
    .busy(busy), .done(done), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected write stream and memory image
  int          addr_q[$];
  logic [31:0] dat_q[$];
  logic [31:0] ref_mem[DEPTH];
  logic [31:0] mem[DEPTH];
  logic [31:0] words[32];

  int          byte_cnt = 0;
  bit          exp_wenb = 1'b0;
  bit          rst_at_edge = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_dat = '0;

  always @(posedge clk) rst_at_edge <= rst;

  // Every cycle: a write must follow exactly one cycle after each 4th accepted byte
  always @(negedge clk) begin
    check("w_enb", w_enb, exp_wenb);
    if (w_enb) begin
      check("in_ready_in_write", in_ready, 0);
      if (addr_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        check("w_addr", w_addr, addr_q.pop_front());
        check("w_dat", w_dat, dat_q.pop_front());
      end
      mem[w_addr] = w_dat;
    end else if (rst_at_edge) begin
      check("w_addr_hold", w_addr, prev_addr);
      check("w_dat_hold", w_dat, prev_dat);
    end
    prev_addr = w_addr;
    prev_dat  = w_dat;
    exp_wenb = 1'b0;
    if (rst && in_valid && in_ready) begin
      exp_wenb = (byte_cnt % 4 == 3);
      byte_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    in_valid = 1'b1;
    in_byte  = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      tries++;
      if (tries > 50) begin
        check("ready_timeout", 0, 1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic gap(input int gap_max);
    int g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic run_load(input int cnt, input int gap_max, input bit inject);
    int n = (cnt > DEPTH) ? DEPTH : cnt;
    int waited = 0;
    @(posedge clk); #1;
    byte_cnt = 0;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(i);
      dat_q.push_back(words[i]);
      ref_mem[i] = words[i];
    end
    start = 1'b1;
    word_count = cnt[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_hold", core_hold, 0);
      repeat (3) @(negedge clk);
      check("zero_no_write", addr_q.size(), 0);
      return;
    end
    check("start_done_low", done, 0);
    check("start_busy", busy, 1);
    check("start_hold", core_hold, 1);
    check("start_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (inject && w == 0 && k == 2) begin
          start = 1'b1;
          word_count = 5'd1;
          @(posedge clk); #1;
          start = 1'b0;
          word_count = cnt[AW:0];
        end
        gap(gap_max);
        send_byte(words[w][8*k +: 8]);
      end
    end
    while (!done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("done", done, 1);
    check("busy_after", busy, 0);
    check("hold_after", core_hold, 0);
    check("writes_left", addr_q.size(), 0);
    for (int i = 0; i < n; i++) check($sformatf("readback%0d", i), mem[i], ref_mem[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_w_enb"}, w_enb, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_w_dat"}, w_dat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_core_hold"}, core_hold, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Program image from a known listing
    words[0] = 32'h00100513; words[1] = 32'h00200593;
    words[2] = 32'h00B58633; words[3] = 32'h0000006F;
    run_load(4, 0, 1'b0);

    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load(2, 7, 1'b0);
    run_load(2, 0, 1'b0);
    run_load(0, 0, 1'b0);
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load(3, 2, 1'b1);
    run_load(20, 0, 1'b0);
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load(16, 3, 1'b0);

    // Abort a 4-word load after 6 bytes
    @(posedge clk); #1;
    byte_cnt = 0;
    addr_q.push_back(0);
    dat_q.push_back(words[0]);
    start = 1'b1;
    word_count = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < 6; b++) send_byte(words[b / 4][8*(b % 4) +: 8]);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    check("abort_writes_left", addr_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load(4, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      run_load($urandom_range(8, 1), $urandom_range(4, 0), r[0]);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, BRAM word-address width (1024 words).
REQ-002 Parameter DATA_WIDTH, default 32, BRAM word width; fixed at 4 bytes.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 word_count  input  ADDR_WIDTH+1  number of words to load; sampled when start is accepted.
REQ-007 in_byte  input  8  incoming program byte.
REQ-008 in_valid  input  1  in_byte valid.
REQ-009 in_ready  output  1  loader accepts in_byte this cycle.
REQ-010 w_addr  output  ADDR_WIDTH  BRAM write word address.
REQ-011 w_dat  output  DATA_WIDTH  BRAM write data.
REQ-012 w_enb  output  1  BRAM write enable, one cycle per word.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load completed; held high until next accepted start or reset.
REQ-015 core_hold  output  1  holds the core in reset; high whenever done is low.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, DONE; no other reachable states.
REQ-017 A byte transfer occurs only in cycles where in_valid and in_ready are both high.
REQ-018 IDLE: in_ready=0, w_enb=0, busy=0, done=0; start=1 -> latch word_count, word index=0, byte index=0; next state RECV.
REQ-019 start with word_count=0 -> next state DONE, no BRAM write.
REQ-020 word_count above 2^ADDR_WIDTH is saturated to 2^ADDR_WIDTH.
REQ-021 RECV: in_ready=1, busy=1; accepted bytes assembled little-endian: byte index k goes to w_dat[8k+7:8k].
REQ-022 RECV: byte index increments modulo 4 on each transfer; on the transfer at index 3 next state is WRITE.
REQ-023 RECV with in_valid=0 holds state, byte index and partial word indefinitely (no timeout).
REQ-024 WRITE: w_enb=1 for exactly that one cycle, w_addr=word index, w_dat=assembled word, in_ready=0, busy=1.
REQ-025 Latency: 4th byte of a word transferred in cycle N -> w_enb high in cycle N+1.
REQ-026 WRITE: if word index equals latched count-1, next state DONE; else word index+1, next state RECV.
REQ-027 Word index wraps never: largest written address is latched count-1 (max 2^ADDR_WIDTH-1).
REQ-028 DONE: done=1, busy=0, in_ready=0, core_hold=0; start=1 restarts exactly as in IDLE.
REQ-029 start while in RECV or WRITE is ignored.
REQ-030 w_addr and w_dat hold their last values when w_enb=0; only w_enb qualifies them.
REQ-031 Minimum throughput is one word per 5 cycles with in_valid held high.

Reset
REQ-032 rst=0 at a clock edge -> state IDLE, in_ready=0, w_enb=0, w_addr=0, w_dat=0, busy=0, done=0, core_hold=1, indices=0.
REQ-033 Reset during RECV or WRITE aborts the load; partial word is discarded and no w_enb pulse occurs in the reset cycle or after it.
REQ-034 Reset has priority over start and in_valid in the same cycle.

Verification
REQ-035 start, word_count=4, bytes 13 05 10 00 | 93 05 20 00 | 33 86 B5 00 | 6F 00 00 00 with in_valid held -> w_enb pulses at w_addr 0..3 with w_dat 00100513, 00200593, 00B58633, 0000006F; done=1 after the 4th write; bram32 readback matches.
REQ-036 4th byte of word 0 accepted at cycle N -> w_enb=1 only at cycle N+1; in_ready=0 at cycle N+1.
REQ-037 in_valid toggled with random gaps (0-7 cycles) during a 2-word load -> identical w_dat/w_addr sequence to the gap-free case; no extra w_enb.
REQ-038 start with word_count=0 -> done=1 within 1 cycle, w_enb never asserted.
REQ-039 rst=0 after 6 bytes of a 4-word load -> all outputs at reset values next cycle; subsequent start loads from address 0 correctly.
REQ-040 start asserted during RECV -> ignored, load completes with original word_count; start in DONE -> new load begins, done drops next cycle.
